// File: rtl/reset_seq_pkg.sv
// Shared types and default constants for the multi-domain reset sequencer.
// The state encoding is also exposed on the sequencer's debug state output.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        RELEASE   = 3'd2,
        DONE      = 3'd3,
        SHUTDOWN  = 3'd4,
        FAULT     = 3'd5
    } seq_state_t;

    localparam int DEF_N_STAGES       = 4;
    localparam int DEF_HOLD_CYCLES    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/reset_seq_sync.sv
// Two-flop synchroniser for an asynchronous level input.
// Both flops clear on reset, so the synchronised level starts at 0.
module reset_seq_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: holds all stage resets after PLL lock, then
// releases stages in order on their ready handshakes, with timeout and shutdown.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_STAGES       = DEF_N_STAGES,
    parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int IDX_W         = (N_STAGES > 1) ? $clog2(N_STAGES) : 1
) (
    input  logic                CLK,
    input  logic                FABRIC_RESET_N,
    input  logic                PLL_LOCK,
    input  logic                SW_RST_REQ,
    input  logic [N_STAGES-1:0] STAGE_READY,
    output logic [N_STAGES-1:0] STAGE_RESET_N,
    output logic                SEQ_DONE,
    output logic                SEQ_FAULT,
    output logic [IDX_W-1:0]    FAULT_STAGE,
    output logic [2:0]          DBG_STATE
);

    localparam int CNT_W = $clog2(max_int(HOLD_CYCLES, TIMEOUT_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] CNT_MAX      = '1;
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N_STAGES - 1);

    logic lock_s;

    seq_state_t          state, state_n;
    logic [IDX_W-1:0]    idx, idx_n;
    logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
    logic [N_STAGES-1:0] stage_rst_q, stage_rst_n;
    logic                done_q, done_n;
    logic                fault_q, fault_n;
    logic [IDX_W-1:0]    fstage_q, fstage_n;

    reset_seq_sync u_lock_sync (
        .clk   (CLK),
        .rst_n (FABRIC_RESET_N),
        .d     (PLL_LOCK),
        .q     (lock_s)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    // Stage handshake: STAGE_RESET_N[i] is the request, STAGE_READY[i] the
    // acknowledge. Ready is only sampled while waiting in RELEASE for stage i;
    // once accepted, later changes on that ready line have no effect.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        cnt_n       = '0;
        stage_rst_n = stage_rst_q;
        done_n      = done_q;
        fault_n     = fault_q;
        fstage_n    = fstage_q;

        unique case (state)
            WAIT_LOCK: begin
                stage_rst_n = '0;
                done_n      = 1'b0;
                idx_n       = '0;
                if (SW_RST_REQ) begin
                    fault_n = 1'b0;
                end
                // A request with lock absent cannot make progress, so only
                // lock moves the sequence forward from here.
                if (lock_s) begin
                    state_n = HOLD;
                end
            end

            HOLD: begin
                cnt_n = cnt_inc;
                if (SW_RST_REQ) begin
                    cnt_n   = '0;
                    fault_n = 1'b0;
                end else if (cnt == HOLD_LAST) begin
                    state_n        = RELEASE;
                    idx_n          = '0;
                    cnt_n          = '0;
                    stage_rst_n    = '0;
                    stage_rst_n[0] = 1'b1;
                end
            end

            RELEASE: begin
                cnt_n = cnt_inc;
                if (SW_RST_REQ) begin
                    state_n     = HOLD;
                    idx_n       = '0;
                    cnt_n       = '0;
                    stage_rst_n = '0;
                    fault_n     = 1'b0;
                end else if (STAGE_READY[idx]) begin
                    cnt_n = '0;
                    if (idx == LAST_IDX) begin
                        state_n = DONE;
                        done_n  = 1'b1;
                    end else begin
                        idx_n              = idx + 1'b1;
                        stage_rst_n[idx_n] = 1'b1;
                    end
                end else if (cnt == TIMEOUT_LAST) begin
                    state_n     = FAULT;
                    cnt_n       = '0;
                    stage_rst_n = '0;
                    fault_n     = 1'b1;
                    fstage_n    = idx;
                end
            end

            DONE: begin
                if (SW_RST_REQ) begin
                    state_n               = SHUTDOWN;
                    done_n                = 1'b0;
                    idx_n                 = LAST_IDX;
                    stage_rst_n[LAST_IDX] = 1'b0;
                end
            end

            // idx names the stage cleared on the previous edge; walk down to 0.
            SHUTDOWN: begin
                if (idx == '0) begin
                    state_n = HOLD;
                end else begin
                    idx_n              = idx - 1'b1;
                    stage_rst_n[idx_n] = 1'b0;
                end
            end

            FAULT: begin
                stage_rst_n = '0;
                if (SW_RST_REQ) begin
                    state_n = HOLD;
                    idx_n   = '0;
                    fault_n = 1'b0;
                end
            end

            default: begin
                state_n     = WAIT_LOCK;
                stage_rst_n = '0;
                done_n      = 1'b0;
                idx_n       = '0;
            end
        endcase

        // Lock loss beats every other condition; fault status survives it.
        if ((state != WAIT_LOCK) && !lock_s) begin
            state_n     = WAIT_LOCK;
            idx_n       = '0;
            cnt_n       = '0;
            stage_rst_n = '0;
            done_n      = 1'b0;
            fault_n     = fault_q;
            fstage_n    = fstage_q;
        end
    end

    always_ff @(posedge CLK or negedge FABRIC_RESET_N) begin
        if (!FABRIC_RESET_N) begin
            state       <= WAIT_LOCK;
            idx         <= '0;
            cnt         <= '0;
            stage_rst_q <= '0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            fstage_q    <= '0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            stage_rst_q <= stage_rst_n;
            done_q      <= done_n;
            fault_q     <= fault_n;
            fstage_q    <= fstage_n;
        end
    end

    assign STAGE_RESET_N = stage_rst_q;
    assign SEQ_DONE      = done_q;
    assign SEQ_FAULT     = fault_q;
    assign FAULT_STAGE   = fstage_q;
    assign DBG_STATE     = state;

endmodule
